cursor_select_ctrl: RTL and testbench

//  Upstream of the VGA display stage. Turns raw push-buttons into the cursor/selection state the display draws.

---
 rtl/cursor_select_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_cursor_select_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cursor_select_ctrl.sv
// Cursor / selection controller: debounces six push-buttons, steps a cursor over
// the 8x8 board, tracks a selected own piece and raises a from/to move request
// that board-update logic answers with MOVE_ACK / MOVE_OK.
module cursor_select_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter logic [5:0]  CURSOR_INIT     = 6'd60
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         BTN_UP,
  input  logic         BTN_DOWN,
  input  logic         BTN_LEFT,
  input  logic         BTN_RIGHT,
  input  logic         BTN_SEL,
  input  logic         BTN_CANCEL,
  input  logic [255:0] BOARD,
  input  logic         TURN,
  input  logic         MOVE_ACK,
  input  logic         MOVE_OK,
  output logic [5:0]   CURSOR_ADDR,
  output logic [5:0]   SELECT_ADDR,
  output logic         SELECT_EN,
  output logic         MOVE_REQ,
  output logic [5:0]   MOVE_FROM,
  output logic [5:0]   MOVE_TO
);

  localparam int unsigned NumBtn = 6;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button order is also the priority order: index 0 wins.
  localparam int unsigned BCancel = 0;
  localparam int unsigned BSel    = 1;
  localparam int unsigned BUp     = 2;
  localparam int unsigned BDown   = 3;
  localparam int unsigned BLeft   = 4;
  localparam int unsigned BRight  = 5;

  typedef enum logic [1:0] {StIdle, StSelected, StMovePend} state_e;

  logic [NumBtn-1:0] raw;
  logic [NumBtn-1:0] sync1_q, sync2_q;
  logic [NumBtn-1:0] level_q, level_prev_q;
  logic [CNT_W-1:0]  cnt_q [NumBtn];
  logic [NumBtn-1:0] press;

  state_e     state_q, state_d;
  logic [5:0] cursor_q, cursor_d;
  logic [5:0] sel_addr_q, sel_addr_d;
  logic       sel_en_q, sel_en_d;
  logic       req_q, req_d;
  logic [5:0] from_q, from_d;
  logic [5:0] to_q, to_d;

  logic       act_cancel, act_sel, act_up, act_down, act_left, act_right;
  logic [3:0] piece;
  logic       own_cur;
  logic       cur_is_sel;

  assign raw = {BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP, BTN_SEL, BTN_CANCEL};

  // Two-flop synchronisers for the asynchronous button inputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a synced level that differs from the accepted level must hold for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the accepted level restarts.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NumBtn; i++) cnt_q[i] <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
    end else begin
      level_prev_q <= level_q;
      for (int i = 0; i < NumBtn; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          cnt_q[i]   <= '0;
          level_q[i] <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // One-cycle press pulses on debounced rising edges, reduced to the single winner.
  always_comb begin
    press      = level_q & ~level_prev_q;
    act_cancel = press[BCancel];
    act_sel    = press[BSel]   & ~press[BCancel];
    act_up     = press[BUp]    & ~|press[BSel:BCancel];
    act_down   = press[BDown]  & ~|press[BUp:BCancel];
    act_left   = press[BLeft]  & ~|press[BDown:BCancel];
    act_right  = press[BRight] & ~|press[BLeft:BCancel];
    piece      = BOARD[{cursor_q, 2'b00} +: 4];
    own_cur    = (piece[2:0] != 3'd0) && (piece[3] == TURN);
    cur_is_sel = (cursor_q == sel_addr_q);
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (act_sel && own_cur) state_d = StSelected;
      end
      StSelected: begin
        if (act_cancel) begin
          state_d = StIdle;
        end else if (act_sel) begin
          if (cur_is_sel)   state_d = StIdle;
          else if (!own_cur) state_d = StMovePend;
        end
      end
      StMovePend: begin
        if (MOVE_ACK) state_d = MOVE_OK ? StIdle : StSelected;
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    cursor_d   = cursor_q;
    sel_addr_d = sel_addr_q;
    sel_en_d   = sel_en_q;
    req_d      = req_q;
    from_d     = from_q;
    to_d       = to_q;

    if (state_q != StMovePend) begin
      if (act_up)    cursor_d[5:3] = cursor_q[5:3] - 3'd1;
      if (act_down)  cursor_d[5:3] = cursor_q[5:3] + 3'd1;
      if (act_left)  cursor_d[2:0] = cursor_q[2:0] - 3'd1;
      if (act_right) cursor_d[2:0] = cursor_q[2:0] + 3'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (act_sel && own_cur) begin
          sel_addr_d = cursor_q;
          sel_en_d   = 1'b1;
        end
      end
      StSelected: begin
        if (act_cancel) begin
          sel_en_d = 1'b0;
        end else if (act_sel) begin
          if (cur_is_sel) begin
            sel_en_d = 1'b0;
          end else if (own_cur) begin
            sel_addr_d = cursor_q;
          end else begin
            req_d  = 1'b1;
            from_d = sel_addr_q;
            to_d   = cursor_q;
          end
        end
      end
      StMovePend: begin
        if (MOVE_ACK) begin
          req_d = 1'b0;
          if (MOVE_OK) sel_en_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cursor_q   <= CURSOR_INIT;
      sel_addr_q <= '0;
      sel_en_q   <= 1'b0;
      req_q      <= 1'b0;
      from_q     <= '0;
      to_q       <= '0;
    end else begin
      cursor_q   <= cursor_d;
      sel_addr_q <= sel_addr_d;
      sel_en_q   <= sel_en_d;
      req_q      <= req_d;
      from_q     <= from_d;
      to_q       <= to_d;
    end
  end

  assign CURSOR_ADDR = cursor_q;
  assign SELECT_ADDR = sel_addr_q;
  assign SELECT_EN   = sel_en_q;
  assign MOVE_REQ    = req_q;
  assign MOVE_FROM   = from_q;
  assign MOVE_TO     = to_q;

endmodule

// File: tb/tb_cursor_select_ctrl.sv
// Bench for cursor_select_ctrl: directed button presses with hand-computed
// expected output snapshots queued per press; a monitor pops one snapshot
// whenever the registered output bundle changes.
module tb_cursor_select_ctrl;

  localparam logic [5:0] MCancel = 6'b000001;
  localparam logic [5:0] MSel    = 6'b000010;
  localparam logic [5:0] MUp     = 6'b000100;
  localparam logic [5:0] MDown   = 6'b001000;
  localparam logic [5:0] MLeft   = 6'b010000;
  localparam logic [5:0] MRight  = 6'b100000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   btn;
  logic [255:0] board;
  logic         turn;
  logic         ack;
  logic         ok;
  logic [5:0]   cursor_addr, select_addr, move_from, move_to;
  logic         select_en, move_req;

  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b0;
  logic [25:0] exp_q [$];

  cursor_select_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .CURSOR_INIT    (6'd60)
  ) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .BTN_UP     (btn[2]),
    .BTN_DOWN   (btn[3]),
    .BTN_LEFT   (btn[4]),
    .BTN_RIGHT  (btn[5]),
    .BTN_SEL    (btn[1]),
    .BTN_CANCEL (btn[0]),
    .BOARD      (board),
    .TURN       (turn),
    .MOVE_ACK   (ack),
    .MOVE_OK    (ok),
    .CURSOR_ADDR(cursor_addr),
    .SELECT_ADDR(select_addr),
    .SELECT_EN  (select_en),
    .MOVE_REQ   (move_req),
    .MOVE_FROM  (move_from),
    .MOVE_TO    (move_to)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] pack(input logic [5:0] c, input logic [5:0] s, input logic en,
                                       input logic req, input logic [5:0] f, input logic [5:0] t);
    return {c, s, en, req, f, t};
  endfunction

  function automatic logic [25:0] outs();
    return {cursor_addr, select_addr, select_en, move_req, move_from, move_to};
  endfunction

  task automatic expect_snap(input logic [5:0] c, input logic [5:0] s, input logic en,
                             input logic req, input logic [5:0] f, input logic [5:0] t);
    exp_q.push_back(pack(c, s, en, req, f, t));
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic press(input logic [5:0] m, input int hold);
    @(negedge clk);
    btn = m;
    repeat (hold) @(negedge clk);
    btn = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic pulse_ack(input logic good);
    @(negedge clk);
    ack = 1'b1;
    ok  = good;
    @(negedge clk);
    ack = 1'b0;
    ok  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every change of the output bundle must match the next queued snapshot.
  logic [25:0] prev_snap;
  always @(negedge clk) begin
    logic [25:0] cur;
    logic [25:0] e;
    cur = outs();
    if (mon_en && cur !== prev_snap) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change: got %h expected no change from %h", cur, prev_snap);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          failures++;
          $display("FAIL snapshot: got c=%0d s=%0d en=%0b req=%0b f=%0d t=%0d expected c=%0d s=%0d en=%0b req=%0b f=%0d t=%0d",
                   cur[25:20], cur[19:14], cur[13], cur[12], cur[11:6], cur[5:0],
                   e[25:20], e[19:14], e[13], e[12], e[11:6], e[5:0]);
        end
      end
    end
    prev_snap = cur;
  end

  initial begin
    int wait_cnt;
    rst_n = 1'b0;
    btn   = '0;
    ack   = 1'b0;
    ok    = 1'b0;
    turn  = 1'b0;
    board = '0;
    board[52*4 +: 4] = 4'b0001;  // white piece
    board[53*4 +: 4] = 4'b1001;  // black piece
    repeat (3) @(negedge clk);
    check("rst_cursor", {2'b0, cursor_addr}, 8'd60);
    check("rst_sel_addr", {2'b0, select_addr}, 8'd0);
    check("rst_sel_en", {7'b0, select_en}, 8'd0);
    check("rst_req", {7'b0, move_req}, 8'd0);
    check("rst_from_to", {move_from[3:0], move_to[3:0]}, 8'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // Long hold gives exactly one step; single-cycle glitch gives none.
    expect_snap(61, 0, 0, 0, 0, 0);
    press(MRight, 20);
    press(MRight, 1);
    check("glitch_cursor", {2'b0, cursor_addr}, 8'd61);

    // Wrap-around: row 7 DOWN -> row 0, col 7 RIGHT -> col 0, row 0 UP -> row 7.
    expect_snap(5, 0, 0, 0, 0, 0);  press(MDown, 10);
    expect_snap(6, 0, 0, 0, 0, 0);  press(MRight, 10);
    expect_snap(7, 0, 0, 0, 0, 0);  press(MRight, 10);
    expect_snap(0, 0, 0, 0, 0, 0);  press(MRight, 10);
    check("wrap_right", {2'b0, cursor_addr}, 8'd0);
    expect_snap(1, 0, 0, 0, 0, 0);  press(MRight, 10);
    expect_snap(2, 0, 0, 0, 0, 0);  press(MRight, 10);
    expect_snap(3, 0, 0, 0, 0, 0);  press(MRight, 10);
    expect_snap(59, 0, 0, 0, 0, 0); press(MUp, 10);
    check("wrap_up", {2'b0, cursor_addr}, 8'd59);

    // UP and LEFT together: UP wins, LEFT discarded.
    expect_snap(51, 0, 0, 0, 0, 0); press(MUp | MLeft, 10);
    check("prio_up_left", {2'b0, cursor_addr}, 8'd51);

    // SEL on empty and on opponent squares does nothing.
    press(MSel, 10);
    check("sel_empty", {7'b0, select_en}, 8'd0);
    expect_snap(52, 0, 0, 0, 0, 0); press(MRight, 10);
    expect_snap(53, 0, 0, 0, 0, 0); press(MRight, 10);
    press(MSel, 10);
    check("sel_black", {7'b0, select_en}, 8'd0);
    expect_snap(52, 0, 0, 0, 0, 0); press(MLeft, 10);

    // Select, move, direction ignored while pending, accepted move.
    expect_snap(52, 52, 1, 0, 0, 0);   press(MSel, 10);
    expect_snap(44, 52, 1, 0, 0, 0);   press(MUp, 10);
    expect_snap(44, 52, 1, 1, 52, 44); press(MSel, 10);
    press(MUp, 10);
    check("pend_up_ignored", {2'b0, cursor_addr}, 8'd44);
    expect_snap(44, 52, 0, 0, 52, 44); pulse_ack(1'b1);

    // Rejected move keeps the selection; CANCEL then drops it.
    expect_snap(52, 52, 0, 0, 52, 44); press(MDown, 10);
    expect_snap(52, 52, 1, 0, 52, 44); press(MSel, 10);
    expect_snap(44, 52, 1, 0, 52, 44); press(MUp, 10);
    expect_snap(44, 52, 1, 1, 52, 44); press(MSel, 10);
    expect_snap(44, 52, 1, 0, 52, 44); pulse_ack(1'b0);
    check("nok_sel_en", {7'b0, select_en}, 8'd1);
    check("nok_sel_addr", {2'b0, select_addr}, 8'd52);
    expect_snap(44, 52, 0, 0, 52, 44); press(MCancel, 10);

    // Reset mid-handshake clears outputs asynchronously; a late ACK is ignored.
    expect_snap(52, 52, 0, 0, 52, 44); press(MDown, 10);
    expect_snap(52, 52, 1, 0, 52, 44); press(MSel, 10);
    expect_snap(44, 52, 1, 0, 52, 44); press(MUp, 10);
    expect_snap(44, 52, 1, 1, 52, 44); press(MSel, 10);
    check("pre_rst_req", {7'b0, move_req}, 8'd1);
    expect_snap(60, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", {7'b0, move_req}, 8'd0);
    check("async_rst_cursor", {2'b0, cursor_addr}, 8'd60);
    check("async_rst_sel_en", {7'b0, select_en}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse_ack(1'b1);
    check("late_ack_req", {7'b0, move_req}, 8'd0);
    expect_snap(61, 0, 0, 0, 0, 0); press(MRight, 10);

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
